// File: rtl/chan_pkg.sv
// chan_pkg: shared definitions for the enabled_channel block.
//   - Default parameter values (data width, FIFO depth, item count, stats width).
//   - FSM state encoding used by the channel controller.
// Optional feature macro used by the block: CHAN_STATS_EN.
package chan_pkg;

    localparam int unsigned CHAN_DW     = 8;
    localparam int unsigned CHAN_DEPTH  = 4;
    localparam int unsigned CHAN_NITEMS = 16;
    localparam int unsigned CHAN_SW     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chan_state_e;

endpackage

// File: rtl/enabled_channel_if.sv
// enabled_channel_if: bundles the enable inputs and observation outputs of
// enabled_channel.
//   master : drives ens/enr, observes everything else (scenario side).
//   slave  : the channel itself.
// Signals: ens, enr (enables); rx_valid, rx_data (delivered item);
//          tx_count, rx_count, level, done (progress);
//          ens_cycles, enr_cycles, ovl_cycles only when CHAN_STATS_EN is defined.
interface enabled_channel_if
    import chan_pkg::*;
#(
    parameter int unsigned DW     = CHAN_DW,
    parameter int unsigned DEPTH  = CHAN_DEPTH,
    parameter int unsigned NITEMS = CHAN_NITEMS,
    parameter int unsigned SW     = CHAN_SW
);
    localparam int unsigned TCW = $clog2(NITEMS + 1);
    localparam int unsigned LW  = $clog2(DEPTH + 1);

    logic           ens;
    logic           enr;
    logic           rx_valid;
    logic [DW-1:0]  rx_data;
    logic [TCW-1:0] tx_count;
    logic [TCW-1:0] rx_count;
    logic [LW-1:0]  level;
    logic           done;
`ifdef CHAN_STATS_EN
    logic [SW-1:0]  ens_cycles;
    logic [SW-1:0]  enr_cycles;
    logic [SW-1:0]  ovl_cycles;

    modport master (
        output ens, enr,
        input  rx_valid, rx_data, tx_count, rx_count, level, done,
        input  ens_cycles, enr_cycles, ovl_cycles
    );
    modport slave (
        input  ens, enr,
        output rx_valid, rx_data, tx_count, rx_count, level, done,
        output ens_cycles, enr_cycles, ovl_cycles
    );
`else
    modport master (
        output ens, enr,
        input  rx_valid, rx_data, tx_count, rx_count, level, done
    );
    modport slave (
        input  ens, enr,
        output rx_valid, rx_data, tx_count, rx_count, level, done
    );
`endif

endinterface

// File: rtl/chan_fifo.sv
// chan_fifo: circular-buffer FIFO with registered read data.
//   clk, rst   : clock, synchronous active-high reset (clears contents too)
//   push_i     : write wr_data_i (honoured when not full, or when a pop
//                happens in the same cycle)
//   pop_i      : read oldest item (honoured only when not empty; no bypass)
//   wr_data_i  : write data
//   rd_valid_o : one-cycle pulse the cycle after an accepted pop
//   rd_data_o  : item popped in the previous cycle
//   full_o, empty_o, level_o : occupancy status
module chan_fifo
    import chan_pkg::*;
#(
    parameter int unsigned DW    = CHAN_DW,
    parameter int unsigned DEPTH = CHAN_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DW-1:0]              wr_data_i,
    output logic                       rd_valid_o,
    output logic [DW-1:0]              rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;

    logic pop_ok, push_ok;

    // Pop sees only items already stored, so push and pop on empty is push only.
    assign pop_ok  = pop_i & (count_q != '0);
    assign push_ok = push_i & ((count_q != DEPTH_C) | pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            rd_valid_q <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign full_o     = (count_q == DEPTH_C);
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;

endmodule

// File: rtl/enabled_channel.sv
// enabled_channel: enable-gated point-to-point transfer channel.
// A built-in sender pushes items 0,1,2,... (mod 2^DW) into chan_fifo while
// ens is high; a built-in receiver pops while enr is high. NITEMS items are
// transferred in total, after which done sticks high until reset.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : enabled_channel_if.slave (ens/enr in; rx_valid, rx_data, tx_count,
//         rx_count, level, done out; stats counters with CHAN_STATS_EN)
// Optional feature macro: CHAN_STATS_EN adds saturating counters of ens,
// enr and ens&enr cycles.
module enabled_channel
    import chan_pkg::*;
#(
    parameter int unsigned DW     = CHAN_DW,
    parameter int unsigned DEPTH  = CHAN_DEPTH,
    parameter int unsigned NITEMS = CHAN_NITEMS,
    parameter int unsigned SW     = CHAN_SW
) (
    input  logic               clk,
    input  logic               rst,
    enabled_channel_if.slave   bus
);
    localparam int unsigned TCW = $clog2(NITEMS + 1);
    localparam int unsigned LW  = $clog2(DEPTH + 1);
    localparam logic [TCW-1:0] NITEMS_C = TCW'(NITEMS);

    chan_state_e    state_q;
    logic           done_q;
    logic [TCW-1:0] tx_count_q, tx_count_d;
    logic [TCW-1:0] rx_count_q, rx_count_d;

    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          fifo_rd_valid;
    logic [DW-1:0] fifo_rd_data;
    logic [DW-1:0] tx_data;

    // Pushes stop in DRAIN/DONE; DONE ignores both enables.
    assign pop  = bus.enr & ~fifo_empty & (state_q != DONE);
    assign push = bus.ens & (tx_count_q < NITEMS_C) & (~fifo_full | pop)
                & ((state_q == IDLE) | (state_q == RUN));

    assign tx_count_d = tx_count_q + TCW'(push);
    assign rx_count_d = rx_count_q + TCW'(pop);
    assign tx_data    = DW'(tx_count_q);

    chan_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .wr_data_i  (tx_data),
        .rd_valid_o (fifo_rd_valid),
        .rd_data_o  (fifo_rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            case (state_q)
                IDLE, RUN: begin
                    // Decided on next-state counts so the last push and last
                    // pop in one cycle go straight to DONE.
                    if (tx_count_d == NITEMS_C) begin
                        if (rx_count_d == NITEMS_C) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (push) begin
                        state_q <= RUN;
                    end
                end
                DRAIN: begin
                    if (rx_count_d == NITEMS_C) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rx_valid = fifo_rd_valid;
    assign bus.rx_data  = fifo_rd_data;
    assign bus.tx_count = tx_count_q;
    assign bus.rx_count = rx_count_q;
    assign bus.level    = fifo_level;
    assign bus.done     = done_q;

`ifdef CHAN_STATS_EN
    logic [SW-1:0] ens_cyc_q, enr_cyc_q, ovl_cyc_q;

    // Counters run in every state, DONE included, and hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ens_cyc_q <= '0;
            enr_cyc_q <= '0;
            ovl_cyc_q <= '0;
        end else begin
            if (bus.ens && (ens_cyc_q != '1)) begin
                ens_cyc_q <= ens_cyc_q + 1'b1;
            end
            if (bus.enr && (enr_cyc_q != '1)) begin
                enr_cyc_q <= enr_cyc_q + 1'b1;
            end
            if (bus.ens && bus.enr && (ovl_cyc_q != '1)) begin
                ovl_cyc_q <= ovl_cyc_q + 1'b1;
            end
        end
    end

    assign bus.ens_cycles = ens_cyc_q;
    assign bus.enr_cycles = enr_cyc_q;
    assign bus.ovl_cycles = ovl_cyc_q;
`endif

endmodule

// File: tb/tb_enabled_channel.sv
// tb_enabled_channel: directed bench for enabled_channel (DW 8, DEPTH 4,
// NITEMS 16, SW 16). Stats checks apply when CHAN_STATS_EN is defined.
module tb_enabled_channel;
    import chan_pkg::*;

    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NITEMS = 16;
    localparam int unsigned SW     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    enabled_channel_if #(.DW(DW), .DEPTH(DEPTH), .NITEMS(NITEMS), .SW(SW)) bus ();

    enabled_channel #(.DW(DW), .DEPTH(DEPTH), .NITEMS(NITEMS), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    logic [DW-1:0] got [$];
    int unsigned   burst       = 0;
    int unsigned   max_burst   = 0;
    bit            seen_drain  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive enables for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic e_s, input logic e_r);
        bus.ens = e_s;
        bus.enr = e_r;
        @(posedge clk);
        #1;
        if (bus.rx_valid === 1'b1) begin
            got.push_back(bus.rx_data);
            burst++;
            if (burst > max_burst) max_burst = burst;
        end else begin
            burst = 0;
        end
        if (dut.state_q == DRAIN) seen_drain = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        got.delete();
        burst      = 0;
        max_burst  = 0;
        seen_drain = 1'b0;
    endtask

    task automatic chk_data(input string tag, input int unsigned n);
        chk({tag, "_cnt"}, got.size(), n);
        for (int unsigned i = 0; i < n; i++) begin
            chk($sformatf("%s_d%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hdead, i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ens = 1'b0;
        bus.enr = 1'b0;

        // Reset state
        do_reset();
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data",  bus.rx_data, 0);
        chk("rst_tx",       bus.tx_count, 0);
        chk("rst_rx",       bus.rx_count, 0);
        chk("rst_level",    bus.level, 0);
        chk("rst_done",     bus.done, 0);
`ifdef CHAN_STATS_EN
        chk("rst_ens_cyc",  bus.ens_cycles, 0);
        chk("rst_enr_cyc",  bus.enr_cycles, 0);
        chk("rst_ovl_cyc",  bus.ovl_cycles, 0);
`endif

        // Both enables for 6 cycles: 6 pushes, 5 pops
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        chk_data("both6", 5);
        chk("both6_level", bus.level, 1);
        chk("both6_tx",    bus.tx_count, 6);
        chk("both6_rx",    bus.rx_count, 5);

        // Sender only: fills and stalls at DEPTH
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("ens_tx",    bus.tx_count, 4);
        chk("ens_level", bus.level, 4);
        chk("ens_nopls", got.size(), 0);
        // Receiver only: drains the 4 items
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk_data("enr", 4);
        chk("enr_level", bus.level, 0);
        chk("enr_rx",    bus.rx_count, 4);
        step(1'b0, 1'b1);
        chk("enr_idle_valid", bus.rx_valid, 0);

        // Full FIFO, then one cycle of both: push and pop together
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("full_level", bus.level, 4);
        step(1'b1, 1'b1);
        chk("fullpp_level", bus.level, 4);
        chk("fullpp_tx",    bus.tx_count, 5);
        chk("fullpp_rx",    bus.rx_count, 1);
        chk("fullpp_valid", bus.rx_valid, 1);
        chk("fullpp_data",  bus.rx_data, 0);

        // Run to completion with both enables high
        for (int k = 0; k < 100 && bus.done !== 1'b1; k++) step(1'b1, 1'b1);
        chk("fin_done",       bus.done, 1);
        chk("fin_last_valid", bus.rx_valid, 1);
        chk("fin_last_data",  bus.rx_data, 15);
        chk_data("fin", 16);
        chk("fin_thruput",    max_burst, 16);
        chk("fin_drain_seen", seen_drain, 1);
        chk("fin_tx",         bus.tx_count, 16);
        chk("fin_rx",         bus.rx_count, 16);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        chk("post_done",  bus.done, 1);
        chk("post_tx",    bus.tx_count, 16);
        chk("post_rx",    bus.rx_count, 16);
        chk("post_level", bus.level, 0);
        chk("post_npls",  got.size(), 16);

        // Alternating non-overlapping 20-cycle windows
        do_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        end
        chk_data("alt", 8);
        chk("alt_tx",    bus.tx_count, 8);
        chk("alt_rx",    bus.rx_count, 8);
        chk("alt_level", bus.level, 0);
        chk("alt_burst", max_burst, 4);
`ifdef CHAN_STATS_EN
        chk("alt_ens_cyc", bus.ens_cycles, 40);
        chk("alt_enr_cyc", bus.enr_cycles, 40);
        chk("alt_ovl_cyc", bus.ovl_cycles, 0);
`endif

        // Reset pulse mid-transfer at level 3
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("mid_level", bus.level, 3);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        chk("mid_tx",    bus.tx_count, 0);
        chk("mid_rx",    bus.rx_count, 0);
        chk("mid_level0", bus.level, 0);
        chk("mid_done",  bus.done, 0);
        chk("mid_valid", bus.rx_valid, 0);
`ifdef CHAN_STATS_EN
        chk("mid_ovl_cyc", bus.ovl_cycles, 0);
`endif
        // First item after reset is 0 again, arriving 2 cycles after ens&enr
        step(1'b1, 1'b1);
        chk("lat_valid1", bus.rx_valid, 0);
        step(1'b1, 1'b1);
        chk("lat_valid2", bus.rx_valid, 1);
        chk("lat_data",   bus.rx_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
